// File: rtl/rtype_instr_issuer.sv
// Generic single-clock FIFO with an occupancy count driving full/empty.
// Latency: a word pushed at edge k is visible at pop_dat after edge k.
// Backpressure: the caller must gate push with !full and pop with !empty.
module rtype_issuer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Encodes R-type/andi/ori field sets into MIPS words and issues them spaced by ISSUE_GAP.
// Latency: a word accepted at edge k issues at edge k+1 at the earliest.
// Backpressure: in_ready = !full (no pass-through on a same-cycle pop); stall inhibits issue.
module rtype_instr_issuer #(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic        issue,
    output logic        err,
    output logic [15:0] issued_count
);
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        STALLED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          push;
    logic          issue_fire;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   head_dat;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (op_sel)
            4'd0:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4'd1:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h22};
            4'd2:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h24};
            4'd3:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4'd4:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h26};
            4'd5:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h27};
            4'd6:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
            4'd7:  enc_word = {6'h00, rs, rt, rd, 5'd0, 6'h2B};
            // Shifts take shamt from imm and leave rs zero.
            4'd8:  enc_word = {6'h00, 5'd0, rt, rd, imm[4:0], 6'h00};
            4'd9:  enc_word = {6'h00, 5'd0, rt, rd, imm[4:0], 6'h02};
            4'd10: enc_word = {6'h0C, rs, rt, imm};
            4'd11: enc_word = {6'h0D, rs, rt, imm};
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && enc_legal;
    assign issue_fire = !fifo_empty && (gap_cnt == '0) && !stall;

    rtype_issuer_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (enc_word),
        .pop      (issue_fire),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_fire)             state_nxt = (ISSUE_GAP > 1) ? HOLD : IDLE;
                else if (stall && !fifo_empty) state_nxt = STALLED;
            end
            HOLD: begin
                if (gap_cnt <= GW'(1))      state_nxt = IDLE;
            end
            STALLED: begin
                if (issue_fire)             state_nxt = (ISSUE_GAP > 1) ? HOLD : IDLE;
                else if (!stall)            state_nxt = IDLE;
            end
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gap_cnt      <= '0;
            instruction  <= '0;
            issue        <= 1'b0;
            err          <= 1'b0;
            issued_count <= '0;
        end else begin
            issue <= issue_fire;
            err   <= accept && !enc_legal;
            if (issue_fire) begin
                gap_cnt      <= GW'(ISSUE_GAP - 1);
                instruction  <= head_dat;
                issued_count <= issued_count + 16'd1;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end
endmodule

// File: tb/tb_rtype_instr_issuer.sv
// Directed bench: stimulus pushes hand-encoded words into a scoreboard queue, a monitor pops on each issue.
module tb_rtype_instr_issuer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op_sel = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [15:0] imm = '0;
    logic        stall = 1'b0;
    logic [31:0] instruction;
    logic        issue;
    logic        err;
    logic [15:0] issued_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [31:0] sb[$];
    int          issue_cyc[$];
    logic [15:0] exp_cnt = '0;

    rtype_instr_issuer #(.DEPTH(4), .ISSUE_GAP(2)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_sel       (op_sel),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .imm          (imm),
        .stall        (stall),
        .instruction  (instruction),
        .issue        (issue),
        .err          (err),
        .issued_count (issued_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every issue pulse must match the oldest expected word and the running count.
    always @(negedge clock) begin
        if (reset_n && issue) begin
            issue_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_issue", instruction, 32'hxxxx_xxxx);
            end else begin
                check("issue_word", instruction, sb.pop_front());
            end
            exp_cnt = exp_cnt + 16'd1;
            check("issued_count", {16'd0, issued_count}, {16'd0, exp_cnt});
        end
    end

    task automatic send(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic legal,
                        input logic [31:0] exp);
        @(negedge clock);
        in_valid = 1'b1; op_sel = o; rs = s; rt = t; rd = d; imm = im;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clock);
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        if (legal) sb.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clock);
            if (issue) seen = 1;
        end
        check(name, seen, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_instruction", instruction, 32'h0);
        check("rst_issue", {31'd0, issue}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_count", {16'd0, issued_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb.delete();
        exp_cnt = '0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        do_reset();

        // Add: issue must appear one cycle after accept, not in the accept cycle.
        send(4'd0, 5'd16, 5'd17, 5'd18, 16'h0000, 1'b1, 32'h02119020);
        @(negedge clock);
        check("no_bypass", {31'd0, issue}, 32'd0);
        @(negedge clock);
        check("add_latency", {31'd0, issue}, 32'd1);

        // srl with rs forced to 0, then the word must stay put.
        send(4'd9, 5'd5, 5'd8, 5'd9, 16'h0004, 1'b1, 32'h00084902);
        wait_issue("srl_issue");
        repeat (3) @(negedge clock);
        check("srl_hold", instruction, 32'h00084902);

        send(4'd11, 5'd8, 5'd9, 5'd31, 16'h00FF, 1'b1, 32'h350900FF);
        wait_issue("ori_issue");

        // Illegal op_sel: err pulse only, nothing enqueued.
        send(4'd13, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 32'h0);
        @(negedge clock);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_ready", {31'd0, in_ready}, 32'd1);
        check("illegal_no_issue", {31'd0, issue}, 32'd0);
        @(negedge clock);
        check("illegal_err_clear", {31'd0, err}, 32'd0);
        check("illegal_count", {16'd0, issued_count}, 32'd3);

        // Fill under stall, then drain with fixed spacing.
        do_reset();
        stall = 1'b1;
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1, 32'h00221824);
        send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b1, 32'h00853022);
        send(4'd5, 5'd7, 5'd8, 5'd10, 16'h0000, 1'b1, 32'h00E85027);
        send(4'd8, 5'd31, 5'd3, 5'd4, 16'hFFE1, 1'b1, 32'h00032040);
        @(negedge clock);
        in_valid = 1'b1; op_sel = 4'd10; rs = 5'd2; rt = 5'd3; rd = 5'd9; imm = 16'hBEEF;
        check("full_not_ready", {31'd0, in_ready}, 32'd0);
        check("stall_no_issue", {31'd0, issue}, 32'd0);
        issue_cyc.delete();
        stall = 1'b0;
        @(negedge clock);
        check("drain_first_issue", {31'd0, issue}, 32'd1);
        check("ready_after_pop", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        sb.push_back(32'h3043BEEF);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 40 && issue_cyc.size() < 5; i++) @(negedge clock);
        check("drain_issues", issue_cyc.size(), 5);
        for (int i = 1; i < 5 && i < issue_cyc.size(); i++) begin
            check("issue_spacing", issue_cyc[i] - issue_cyc[i-1], 2);
        end
        check("drain_count", {16'd0, issued_count}, 32'd5);
        check("drain_sb_empty", sb.size(), 0);

        // Reset while holding after the first issue.
        do_reset();
        stall = 1'b1;
        send(4'd4, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b1, 32'h00210826);
        send(4'd6, 5'd2, 5'd3, 5'd4, 16'h0000, 1'b1, 32'h0043202A);
        send(4'd7, 5'd9, 5'd10, 5'd11, 16'h0000, 1'b1, 32'h012A582B);
        @(negedge clock);
        stall = 1'b0;
        wait_issue("pre_reset_issue");
        #1 reset_n = 1'b0;
        #1;
        check("async_instruction", instruction, 32'h0);
        check("async_issue", {31'd0, issue}, 32'd0);
        check("async_count", {16'd0, issued_count}, 32'd0);
        sb.delete();
        exp_cnt = '0;
        @(negedge clock);
        reset_n = 1'b1;
        quiet = 1;
        repeat (6) begin
            @(negedge clock);
            if (issue) quiet = 0;
        end
        check("post_reset_quiet", quiet, 1);
        send(4'd3, 5'd3, 5'd4, 5'd5, 16'h0000, 1'b1, 32'h00642825);
        wait_issue("post_reset_issue");
        check("post_reset_count", {16'd0, issued_count}, 32'd1);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
